// File: rtl/apple_bus_pkg.sv
// apple_bus_pkg: shared Apple II slot-bus constants, bus state and slot address helpers
package apple_bus_pkg;
  localparam logic [15:0] IO_PAGE      = 16'hC000;
  localparam logic [15:0] DEVSEL_BASE  = 16'hC080;
  localparam logic [15:0] EXP_ROM_BASE = 16'hC800;
  localparam logic [15:0] EXP_ROM_END  = 16'hCFFF;
  typedef enum logic {IDLE, ACTIVE} bus_state_e;
  function automatic logic [15:0] slot_page(input int slot);
    return IO_PAGE | 16'(slot << 8);
  endfunction
  function automatic logic [15:0] devsel_base(input int slot);
    return DEVSEL_BASE + 16'(slot << 4);
  endfunction
endpackage

// File: rtl/apple_bus_strobe_decode.sv
// apple_bus_strobe_decode: maps a bus address to the active-high iosel/iostrobe/devsel enables of one slot
module apple_bus_strobe_decode
  import apple_bus_pkg::*;
#(
  parameter int SLOT = 6
) (
  input  logic [15:0] addr_i,
  output logic        iosel_o,
  output logic        iostrobe_o,
  output logic        devsel_o
);
  localparam logic [15:0] PAGE = slot_page(SLOT);
  localparam logic [15:0] DEV  = devsel_base(SLOT);
  assign iosel_o    = addr_i[15:8] == PAGE[15:8];
  assign devsel_o   = addr_i[15:4] == DEV[15:4];
  assign iostrobe_o = addr_i >= EXP_ROM_BASE && addr_i <= EXP_ROM_END;
endmodule

// File: rtl/apple_bus_master.sv
// apple_bus_master: Apple II slot-bus initiator generating phi0, address, R/W, data and slot strobes.
// Define APPLE_BUS_RESET_OUT_EN to add the _bus_reset output held low for RESET_HOLD_BUS_CYCLES bus cycles.
module apple_bus_master
  import apple_bus_pkg::*;
#(
  parameter int SLOT             = 6,
  parameter int PHI0_LOW_CYCLES  = 7,
  parameter int PHI0_HIGH_CYCLES = 7
`ifdef APPLE_BUS_RESET_OUT_EN
  ,
  parameter int RESET_HOLD_BUS_CYCLES = 4
`endif
) (
  input  logic        fclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        phi0,
  output logic [15:0] addr,
  output logic        rw,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        _iosel,
  output logic        _iostrobe,
  output logic        _devsel
`ifdef APPLE_BUS_RESET_OUT_EN
  ,
  output logic        _bus_reset
`endif
);
  localparam int N  = PHI0_LOW_CYCLES + PHI0_HIGH_CYCLES;
  localparam int CW = $clog2(N);
  logic [CW-1:0] cnt_q, cnt_d;
  bus_state_e    state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_out_q, data_out_d, resp_rdata_q, resp_rdata_d;
  logic          rw_q, rw_d, phi0_q, phi0_d, data_oe_q, data_oe_d;
  logic          iosel_n_q, iosel_n_d, iostrobe_n_q, iostrobe_n_d, devsel_n_q, devsel_n_d;
  logic          resp_valid_q, resp_valid_d;
  logic          last, hs, en_d, bus_ok;
  logic          dec_iosel, dec_iostrobe, dec_devsel;
  assign last      = cnt_q == CW'(N - 1);
  assign cnt_d     = last ? '0 : cnt_q + 1'b1;
  assign req_ready = cnt_q == '0 && !reset && bus_ok;
  assign hs        = req_valid && req_ready;
  assign state_d   = hs ? ACTIVE : last ? IDLE : state_q;
  assign addr_d    = hs ? req_addr : addr_q;
  assign rw_d      = hs ? !req_we : last ? 1'b1 : rw_q;
  assign data_out_d = hs ? req_wdata : data_out_q;
  assign phi0_d    = cnt_d >= CW'(PHI0_LOW_CYCLES);
  // strobes and data_oe cover exactly the phi0-high phase of an active bus cycle
  assign en_d      = state_d == ACTIVE && phi0_d && bus_ok;
  assign iosel_n_d    = !(en_d && dec_iosel);
  assign iostrobe_n_d = !(en_d && dec_iostrobe);
  assign devsel_n_d   = !(en_d && dec_devsel);
  assign data_oe_d    = en_d && !rw_d;
  assign resp_valid_d = last && state_q == ACTIVE;
  assign resp_rdata_d = resp_valid_d ? (rw_q ? data_in : 8'h00) : resp_rdata_q;
  apple_bus_strobe_decode #(.SLOT(SLOT)) u_dec (
    .addr_i     (addr_d),
    .iosel_o    (dec_iosel),
    .iostrobe_o (dec_iostrobe),
    .devsel_o   (dec_devsel)
  );
  always_ff @(posedge fclk) begin
    if (reset) begin
      cnt_q        <= '0;
      state_q      <= IDLE;
      phi0_q       <= 1'b0;
      addr_q       <= 16'h0000;
      rw_q         <= 1'b1;
      data_out_q   <= 8'h00;
      data_oe_q    <= 1'b0;
      iosel_n_q    <= 1'b1;
      iostrobe_n_q <= 1'b1;
      devsel_n_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'h00;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      phi0_q       <= phi0_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      iosel_n_q    <= iosel_n_d;
      iostrobe_n_q <= iostrobe_n_d;
      devsel_n_q   <= devsel_n_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign phi0       = phi0_q;
  assign addr       = addr_q;
  assign rw         = rw_q;
  assign data_out   = data_out_q;
  assign data_oe    = data_oe_q;
  assign _iosel     = iosel_n_q;
  assign _iostrobe  = iostrobe_n_q;
  assign _devsel    = devsel_n_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
`ifdef APPLE_BUS_RESET_OUT_EN
  localparam int HW = $clog2(RESET_HOLD_BUS_CYCLES + 2);
  logic [HW-1:0] hold_q;
  logic          bus_ok_q;
  // count complete bus cycles after reset; release lands on the edge entering cnt == 0
  always_ff @(posedge fclk) begin
    if (reset) begin
      hold_q   <= '0;
      bus_ok_q <= RESET_HOLD_BUS_CYCLES == 0;
    end else if (last && !bus_ok_q) begin
      hold_q   <= hold_q + 1'b1;
      bus_ok_q <= hold_q == HW'(RESET_HOLD_BUS_CYCLES - 1);
    end
  end
  assign bus_ok     = bus_ok_q;
  assign _bus_reset = bus_ok_q;
`else
  assign bus_ok = 1'b1;
`endif
endmodule

// File: tb/tb_apple_bus_master.sv
// tb_apple_bus_master: randomized bench for apple_bus_master against a cycle-accurate bus-cycle reference model
module tb_apple_bus_master;
  localparam int SLOT = 6;
  localparam int L    = 7;
  localparam int CYC  = 14;
  localparam int NB   = 1024;
`ifdef APPLE_BUS_RESET_OUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 0;
`endif
  localparam logic [15:0] IO_LO  = 16'hC000 + 16'(SLOT * 256);
  localparam logic [15:0] DEV_LO = 16'hC080 + 16'(SLOT * 16);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0000;
  logic        req_we = 1'b0;
  logic [7:0]  req_wdata = 8'h00;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        phi0;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        _iosel, _iostrobe, _devsel;
`ifdef APPLE_BUS_RESET_OUT_EN
  logic        _bus_reset;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  rmem [256];
  int          t = 0;
  bit          started = 0;
  bit          tv [NB];
  logic [15:0] ta [NB];
  logic        tw [NB];
  logic [15:0] last_addr = 16'h0000;
  logic [7:0]  last_wdata = 8'h00;

  always #5 clk = ~clk;

  assign data_in = rmem[addr[7:0]];

  apple_bus_master #(.SLOT(SLOT), .PHI0_LOW_CYCLES(L), .PHI0_HIGH_CYCLES(CYC - L)) dut (
    .fclk       (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .phi0       (phi0),
    .addr       (addr),
    .rw         (rw),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .data_in    (data_in),
    ._iosel     (_iosel),
    ._iostrobe  (_iostrobe),
    ._devsel    (_devsel)
`ifdef APPLE_BUS_RESET_OUT_EN
    ,
    ._bus_reset (_bus_reset)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: t counts fclk since reset, bus cycle b = t / CYC owns phases 1..CYC-1 after its handshake
  always @(posedge clk) begin
    if (reset) begin
      t <= 0;
      started <= 1;
      last_addr <= 16'h0000;
      last_wdata <= 8'h00;
      foreach (tv[i]) tv[i] <= 0;
    end else begin
      t <= t + 1;
      if (req_valid && t % CYC == 0 && t >= HOLD * CYC && t / CYC < NB) begin
        tv[t / CYC] <= 1;
        ta[t / CYC] <= req_addr;
        tw[t / CYC] <= req_we;
        last_addr <= req_addr;
        last_wdata <= req_wdata;
      end
    end
  end

  always @(negedge clk) if (started) begin
    int p, b;
    logic act, en, up, rv;
    logic [15:0] a;
    p = t % CYC;
    b = t / CYC;
    up = t >= HOLD * CYC;
    act = p != 0 && b < NB && tv[b];
    a = act ? ta[b] : 16'h0000;
    en = act && p >= L;
    rv = p == 0 && b >= 1 && b <= NB && tv[b - 1];
    check("phi0", 32'(phi0), 32'(p >= L));
    check("rw", 32'(rw), act ? 32'(!tw[b]) : 32'd1);
    check("addr", 32'(addr), 32'(last_addr));
    check("data_out", 32'(data_out), 32'(last_wdata));
    check("data_oe", 32'(data_oe), 32'(en && tw[b]));
    check("iosel", 32'(_iosel), 32'(!(en && a >= IO_LO && a <= IO_LO + 16'h00FF)));
    check("devsel", 32'(_devsel), 32'(!(en && a >= DEV_LO && a <= DEV_LO + 16'h000F)));
    check("iostrobe", 32'(_iostrobe), 32'(!(en && a >= 16'hC800 && a <= 16'hCFFF)));
    check("req_ready", 32'(req_ready), 32'(p == 0 && !reset && up));
    check("resp_valid", 32'(resp_valid), 32'(rv));
    if (rv) check("resp_rdata", 32'(resp_rdata), tw[b - 1] ? 32'd0 : 32'(rmem[ta[b - 1][7:0]]));
`ifdef APPLE_BUS_RESET_OUT_EN
    check("bus_reset", 32'(_bus_reset), 32'(up));
`endif
  end

  task automatic send(input logic [15:0] a, input logic we, input logic [7:0] wd);
    bit ok;
    ok = 0;
    req_addr = a;
    req_we = we;
    req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      check("hs_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] edges [10];
    edges = '{16'hC5FF, 16'hC600, 16'hC6FF, 16'hC700, 16'hC0DF,
              16'hC0E0, 16'hC0EF, 16'hC0F0, 16'hC7FF, 16'hD000};
    case ($urandom_range(0, 4))
      0: return 16'hC600 | 16'($urandom_range(0, 255));
      1: return 16'hC0E0 | 16'($urandom_range(0, 15));
      2: return 16'hC800 + 16'($urandom_range(0, 2047));
      3: return 16'($urandom);
      default: return edges[$urandom_range(0, 9)];
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (rmem[i]) rmem[i] = 8'($urandom);
    rmem[0] = 8'hA9;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    send(16'hC600, 1'b0, 8'h00);
    idle(1);
    send(16'hC0E0, 1'b1, 8'h5A);
    send(16'hC800, 1'b0, 8'h00);
    send(16'hCFFF, 1'b0, 8'h00);
    idle(20);
    send(16'hC0E0, 1'b1, 8'h5A);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(req_ready), 32'(HOLD == 0));
    @(posedge clk);
    #2;
    idle(3 * CYC);
    send(16'h0300, 1'b0, 8'h00);
    idle(5);
    for (int n = 0; n < 60; n++) begin
      send(pick_addr(), 1'($urandom_range(0, 1)), 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
    end
    idle(2 * CYC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
